// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder: one CHUNK-bit CLA group per stage, with a
// registered carry between stages. Full-pipe valid/ready flow control. Subtract support is built only with CLA_PIPE_SUB_EN.
module cla_pipe_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   sum
);

   // WIDTH must be a multiple of CHUNK.
   localparam int NSTAGE = WIDTH / CHUNK;

   logic             w_adv;
   logic [WIDTH-1:0] w_b0;
   logic             w_c0;

   // Two-level lookahead inside one group: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
   function automatic logic [CHUNK:0] cla_carries(input logic [CHUNK-1:0] g,
                                                   input logic [CHUNK-1:0] p,
                                                   input logic             cin);
      logic [CHUNK:0] c;
      logic           pp;
      c[0] = cin;
      for (int i = 0; i < CHUNK; i++) begin
         c[i+1] = 1'b0;
         pp     = 1'b1;
         for (int j = i; j >= 0; j--) begin
            c[i+1] = c[i+1] | (pp & g[j]);
            pp     = pp & p[j];
         end
         c[i+1] = c[i+1] | (pp & cin);
      end
      return c;
   endfunction

`ifdef CLA_PIPE_SUB_EN
   assign w_b0 = sub ? ~b : b;
   assign w_c0 = sub ? 1'b1 : ci;
`else
   logic w_sub_unused;
   assign w_sub_unused = sub;
   assign w_b0         = b;
   assign w_c0         = ci;
`endif

   generate
      for (genvar k = 0; k < NSTAGE; k++) begin : g_stg
         localparam int LO  = k * CHUNK;
         localparam int REM = WIDTH - LO;

         logic [REM-1:0]        w_ain;
         logic [REM-1:0]        w_bin;
         logic                  w_cin;
         logic                  w_vin;
         logic [CHUNK-1:0]      w_g;
         logic [CHUNK-1:0]      w_p;
         logic [CHUNK-1:0]      w_s;
         logic [CHUNK:0]        w_c;
         logic [LO+CHUNK-1:0]   w_sum_nxt;
         logic                  r_vld;
         logic                  r_cry;
         logic [LO+CHUNK-1:0]   r_sum;

         if (k == 0) begin : g_src
            assign w_ain     = a;
            assign w_bin     = w_b0;
            assign w_cin     = w_c0;
            assign w_vin     = in_valid;
            assign w_sum_nxt = w_s;
         end else begin : g_src
            assign w_ain     = g_stg[k-1].g_skew.r_a;
            assign w_bin     = g_stg[k-1].g_skew.r_b;
            assign w_cin     = g_stg[k-1].r_cry;
            assign w_vin     = g_stg[k-1].r_vld;
            assign w_sum_nxt = {w_s, g_stg[k-1].r_sum};
         end

         assign w_g = w_ain[CHUNK-1:0] & w_bin[CHUNK-1:0];
         assign w_p = w_ain[CHUNK-1:0] ^ w_bin[CHUNK-1:0];
         assign w_c = cla_carries(w_g, w_p, w_cin);
         assign w_s = w_p ^ w_c[CHUNK-1:0];

         always_ff @(posedge clk) begin
            if (rst) begin
               r_vld <= 1'b0;
               r_cry <= 1'b0;
               r_sum <= '0;
            end else if (w_adv) begin
               r_vld <= w_vin;
               r_cry <= w_c[CHUNK];
               r_sum <= w_sum_nxt;
            end
         end

         // Operand skew: bits not yet resolved travel with the beat.
         if (k < NSTAGE - 1) begin : g_skew
            logic [REM-CHUNK-1:0] r_a;
            logic [REM-CHUNK-1:0] r_b;
            always_ff @(posedge clk) begin
               if (rst) begin
                  r_a <= '0;
                  r_b <= '0;
               end else if (w_adv) begin
                  r_a <= w_ain[REM-1:CHUNK];
                  r_b <= w_bin[REM-1:CHUNK];
               end
            end
         end
      end
   endgenerate

   assign out_valid = g_stg[NSTAGE-1].r_vld;
   assign sum       = {g_stg[NSTAGE-1].r_cry, g_stg[NSTAGE-1].r_sum};
   assign w_adv     = !out_valid || out_ready;
   assign in_ready  = w_adv;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed self-checking bench for cla_pipe_adder (WIDTH=16, CHUNK=4).
// Subtract expectation follows CLA_PIPE_SUB_EN.
module tb_cla_pipe_adder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        ci;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [16:0] sum;

   int checks = 0;
   int errors = 0;

   cla_pipe_adder #(.WIDTH(16), .CHUNK(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .ci(ci), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready), .sum(sum)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One beat into an empty pipe; measures latency in edges after the accepting edge.
   task automatic send_one(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                           input logic tci, input logic tsub, input logic [16:0] exp);
      int lat;
      @(negedge clk);
      a = ta; b = tb; ci = tci; sub = tsub; in_valid = 1'b1;
      chk({tag, "_in_ready"}, in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_latency"}, lat, 3);
      chk({tag, "_sum"}, sum, exp);
   endtask

   logic [15:0] va [5];
   logic [15:0] vb [5];
   logic        vc [5];
   logic [16:0] ve [5];
   int          idx;
   int          seen;

   initial begin
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", sum, 0);
      chk("rst_in_ready", in_ready, 1);

      send_one("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000);
      send_one("carry_in", 16'h1234, 16'h4321, 1'b1, 1'b0, 17'h05556);

      // Back-to-back beats with out_ready held high.
      va = '{16'h0001, 16'h00FF, 16'h8000, 16'hAAAA, 16'h0000};
      vb = '{16'h0001, 16'h0001, 16'h8000, 16'h5555, 16'h0000};
      ve = '{17'h00002, 17'h00100, 17'h10000, 17'h0FFFF, 17'h00000};
      repeat (2) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         a = va[i]; b = vb[i]; ci = 1'b0; in_valid = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      idx = 0;
      while (!out_valid && idx < 20) begin
         @(negedge clk);
         idx++;
      end
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("b2b_valid%0d", i), out_valid, 1);
         chk($sformatf("b2b_sum%0d", i), sum, ve[i]);
         @(negedge clk);
      end
      chk("b2b_drained", out_valid, 0);

      // Backpressure: fill four stages, stall five cycles with a fifth beat waiting.
      va = '{16'h0010, 16'hFFFF, 16'h7FFF, 16'h0F0F, 16'h1111};
      vb = '{16'h0020, 16'hFFFF, 16'h0001, 16'hF0F0, 16'h2222};
      vc = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      ve = '{17'h00030, 17'h1FFFE, 17'h08000, 17'h10000, 17'h03333};
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         a = va[i]; b = vb[i]; ci = vc[i]; in_valid = 1'b1;
      end
      @(negedge clk);
      a = va[4]; b = vb[4]; ci = vc[4];
      chk("bp_full_in_ready", in_ready, 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("bp_hold_valid%0d", i), out_valid, 1);
         chk($sformatf("bp_hold_sum%0d", i), sum, ve[0]);
         chk($sformatf("bp_hold_ready%0d", i), in_ready, 0);
      end
      out_ready = 1'b1;
      idx = 0;
      for (int n = 0; n < 20; n++) begin
         if (out_valid) begin
            if (idx < 5) chk($sformatf("bp_order%0d", idx), sum, ve[idx]);
            idx++;
         end
         @(negedge clk);
         if (n == 0) in_valid = 1'b0;
      end
      chk("bp_beat_count", idx, 5);

      // Reset with three beats in flight.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         a = 16'h1000; b = 16'h0100; ci = 1'b0; in_valid = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_sum", sum, 0);
      chk("midrst_in_ready", in_ready, 1);
      seen = 0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("midrst_no_stale", seen, 0);

`ifdef CLA_PIPE_SUB_EN
      send_one("subtract", 16'h0005, 16'h0007, 1'b0, 1'b1, 17'h0FFFE);
`else
      send_one("subtract", 16'h0005, 16'h0007, 1'b0, 1'b1, 17'h0000C);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
